ram_bus_master: RTL
===================

// Module: ram_bus_master
// PURPOSE
//   Initiator for the synchronous single-port RAM bus (address, shared tri-state data, cs/we/oe).
//   Converts a valid/ready request port into correctly timed RAM write and read cycles.
//   Owns bus direction, including the turnaround between RAM-driven and master-driven data.
//   Returns read data on a one-cycle response strobe. Sits between the datapath/CPU and the RAM.
// PARAMETERS
//   DATA_WIDTH  16  width of the data bus, req_wdata and rsp_rdata
//   ADDR_WIDTH   8  width of the RAM address
// PORTS
//   clk          in    1           single clock; all state changes on posedge
//   rst          in    1           asynchronous, active-high reset
//   req_valid    in    1           request present
//   req_ready    out   1           request accepted at a posedge when req_valid && req_ready
//   req_we       in    1           1 = write, 0 = read
//   req_addr     in    ADDR_WIDTH  request address
//   req_wdata    in    DATA_WIDTH  write data, used only when req_we = 1
//   rsp_valid    out   1           one-cycle pulse: rsp_rdata holds read result
//   rsp_rdata    out   DATA_WIDTH  read data; holds its value until the next read completes
//   busy         out   1           state != IDLE
//   mem_address  out   ADDR_WIDTH  RAM address (registered)
//   mem_data     inout DATA_WIDTH  RAM data; driven only in WRITE, else high-Z
//   mem_cs       out   1           RAM chip select (registered)
//   mem_we       out   1           RAM write enable (registered)
//   mem_oe       out   1           RAM output enable (registered)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; mem_cs/we/oe=0; mem_address=0; mem_data=Z;
//     rsp_valid=0; rsp_rdata=0.
//   Reset mid-operation: the transfer is abandoned and no rsp_valid is produced.
//     Because cs drops before the next edge, a pending write does not commit.
//   FSM states: IDLE, WRITE, READ_A, READ_D, TURN. All mem_* controls are registered from
//     the next state, so every control is clean for a whole cycle.
//   req_ready = state in {IDLE, WRITE, READ_D}. It is 0 in READ_A and TURN.
//   IDLE:   cs=we=oe=0, bus Z. Accept write -> WRITE; accept read -> READ_A; else stay.
//   WRITE:  cs=1, we=1, oe=0. Drive mem_data with latched wdata; the RAM commits at the
//           ending edge. Accept write -> WRITE (back-to-back, 1 write/cycle). Accept read
//           -> READ_A. No request -> IDLE.
//   READ_A: cs=1, oe=1, we=0, address latched. The RAM registers the word at the ending
//           edge. -> READ_D unconditionally.
//   READ_D: cs=1, oe=1, we=0, same address. The RAM drives the bus. At the ending edge,
//           capture mem_data -> rsp_rdata and set rsp_valid=1 for exactly the next cycle.
//           Accept read -> READ_A (new address; cs/oe stay 1; 1 read per 2 cycles).
//           Accept write -> TURN, latching addr/wdata. No request -> IDLE.
//   TURN:   cs=we=oe=0, bus Z for one cycle (bus turnaround). -> WRITE with latched request.
//   Bus rule: master drive enable and mem_oe are never 1 in the same cycle. A read never
//     directly precedes a write without TURN.
//   Latency (accept edge = E0): a write commits at E1. For a read, the RAM samples at E1,
//     the master captures at E2, and rsp_valid is high during the cycle after E2.
//   rsp_valid is also set in a cycle where a new request is accepted; there is no response
//     backpressure.
//   Request fields are sampled only at the accept edge; changes while not ready are ignored.
//   Address and data widths pass through unchanged; there is no arithmetic on addresses.
// STRUCTURE
//   Shared include ram_bus_defs.vh: state encodings (IDLE..TURN as localparams), and
//     DATA_WIDTH/ADDR_WIDTH defaults shared with the RAM.
//   No sub-module: one FSM always block, one registered output block, and one continuous
//     assign for the tri-state.
//   The bench instantiates this block together with the existing RAM model on a shared
//     mem_data net.
// TESTING
//   1 Reset: hold rst mid-cycle -> all mem_* outputs 0 at once, mem_data Z, busy=0,
//     req_ready=1.
//   2 Write 0x00A5<-0x1234, then read 0x00A5 -> rsp_valid pulses 1 cycle, two cycles after
//     the read-accept edge; rsp_rdata=0x1234.
//   3 Writes to 0x01,0x02,0x03 back-to-back (req_valid held) -> 3 accepts on consecutive
//     edges; readback gives 0x1111,0x2222,0x3333.
//   4 Read 0x01 immediately followed by write 0x01<-0xBEEF -> TURN cycle has cs=0 and bus Z;
//     the read returns the old value, and a later read returns 0xBEEF.
//   5 Read addresses 0xFF then 0x00 back-to-back -> req_ready low only in READ_A; two
//     rsp_valid pulses 2 cycles apart with the correct data.
//   6 Assert rst during WRITE, before the commit edge -> a later read of that address returns
//     its prior value; no rsp_valid; a bus monitor flags no cycle with master drive and
//     mem_oe both high.

Source files
------------

// File: rtl/ram_bus_master_pkg.sv
// Shared types and defaults for the RAM bus initiator: FSM states, per-cycle
// RAM control bundle and the state-to-control decode.
package ram_bus_master_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ_A = 3'd2,
    ST_READ_D = 3'd3,
    ST_TURN   = 3'd4
  } state_t;

  typedef struct packed {
    logic cs;
    logic we;
    logic oe;
    logic drive;
  } mem_ctrl_t;

  // RAM controls that apply for a whole cycle spent in state s
  function automatic mem_ctrl_t ctrl_for(state_t s);
    mem_ctrl_t c;
    c = '0;
    case (s)
      ST_WRITE: begin
        c.cs    = 1'b1;
        c.we    = 1'b1;
        c.drive = 1'b1;
      end
      ST_READ_A, ST_READ_D: begin
        c.cs = 1'b1;
        c.oe = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram_bus_master_if.sv
// Request/response port and RAM control signals of the RAM bus initiator.
// The shared tri-state data net stays a plain inout on the master.
interface ram_bus_master_if
  import ram_bus_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output mem_address, mem_cs, mem_we, mem_oe
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  mem_address, mem_cs, mem_we, mem_oe
  );

endinterface

// File: rtl/ram_bus_master.sv
// Initiator for the synchronous single-port RAM: turns valid/ready requests into
// timed write/read cycles and owns data-bus direction including read->write turnaround.
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_bus_master_if.master      bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_t                r_state;
  state_t                w_next;
  mem_ctrl_t             w_ctrl;
  logic                  w_accept;

  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_drive;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Ready only where the following cycle can take a new transfer
  assign bus.req_ready = (r_state == ST_IDLE) || (r_state == ST_WRITE) ||
                         (r_state == ST_READ_D);
  assign bus.busy      = (r_state != ST_IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = bus.req_we ? ST_WRITE : ST_READ_A;
      end
      ST_WRITE: begin
        if (w_accept) w_next = bus.req_we ? ST_WRITE : ST_READ_A;
        else          w_next = ST_IDLE;
      end
      ST_READ_A: w_next = ST_READ_D;
      ST_READ_D: begin
        // A write after a read must pass through TURN so the RAM releases the bus
        if (w_accept) w_next = bus.req_we ? ST_TURN : ST_READ_A;
        else          w_next = ST_IDLE;
      end
      ST_TURN: w_next = ST_WRITE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    w_ctrl = ctrl_for(w_next);
  end

  // RAM controls are registered from the next state so each is stable for a full cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_drive     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_cs        <= w_ctrl.cs;
      r_we        <= w_ctrl.we;
      r_oe        <= w_ctrl.oe;
      r_drive     <= w_ctrl.drive;
      r_rsp_valid <= (r_state == ST_READ_D);
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == ST_READ_D) r_rsp_rdata <= mem_data;
    end
  end

  assign bus.mem_cs      = r_cs;
  assign bus.mem_we      = r_we;
  assign bus.mem_oe      = r_oe;
  assign bus.mem_address = r_addr;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;

  assign mem_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule
